// File: rtl/axi_master.sv
// rtl/axi_master.sv - single-outstanding AXI initiator bridging a command/response client to an AXI slave
module axi_master #(
  parameter int addr_width = 3,
  parameter int data_width = 32,
  parameter int strb       = 4,
  parameter int resp       = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  // local command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [data_width-1:0] cmd_wdata,
  input  logic [strb-1:0]       cmd_wstrb,
  // local response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic [resp-1:0]       rsp_resp,
  // write address channel
  output logic                  awid,
  output logic [addr_width-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  // write data channel
  output logic [data_width-1:0] wdata,
  output logic [strb-1:0]       wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // write response channel
  input  logic [resp-1:0]       bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // read address channel
  output logic                  arid,
  output logic [addr_width-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  // read data channel
  input  logic [data_width-1:0] rdata,
  input  logic [resp-1:0]       rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_RESP
  } state_t;

  // SLVERR-style code reported when a read beat arrives without rlast
  localparam logic [resp-1:0] RESP_PROTO_ERR = resp'(2'b10);

  state_t                r_state;
  state_t                w_next;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [addr_width-1:0] r_addr;
  logic [data_width-1:0] r_wdata;
  logic [strb-1:0]       r_wstrb;
  logic [data_width-1:0] r_rsp_rdata;
  logic [resp-1:0]       r_rsp_resp;

  logic w_cmd_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;
  logic w_ar_fire;
  logic w_r_fire;
  logic w_rsp_fire;

  // Handshakes are derived from state and registered flags only, so the
  // valid/ready outputs never depend combinationally on slave inputs.
  assign w_cmd_fire = (r_state == S_IDLE)  && cmd_valid;
  assign w_aw_fire  = (r_state == S_WRITE) && !r_aw_done && awready;
  assign w_w_fire   = (r_state == S_WRITE) && !r_w_done  && wready;
  assign w_b_fire   = (r_state == S_WRESP) && bvalid;
  assign w_ar_fire  = (r_state == S_RADDR) && arready;
  assign w_r_fire   = (r_state == S_RDATA) && rvalid;
  assign w_rsp_fire = (r_state == S_RESP)  && rsp_ready;

  // Fixed single-beat, 4-byte, INCR burst attributes and payload from the captured command
  assign awid      = 1'b0;
  assign awlen     = 8'd0;
  assign awsize    = 3'b010;
  assign awburst   = 2'b01;
  assign arid      = 1'b0;
  assign arlen     = 8'd0;
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;
  assign wlast     = 1'b1;
  assign awaddr    = r_addr;
  assign araddr    = r_addr;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state channel controls
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (w_cmd_fire) begin
          w_next = cmd_write ? S_WRITE : S_RADDR;
        end
      end
      S_WRITE: begin
        // AW and W complete independently; leave once both have been taken
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
          w_next = S_WRESP;
        end
      end
      S_WRESP: begin
        bready = 1'b1;
        if (w_b_fire) begin
          w_next = S_RESP;
        end
      end
      S_RADDR: begin
        arvalid = 1'b1;
        if (w_ar_fire) begin
          w_next = S_RDATA;
        end
      end
      S_RDATA: begin
        rready = 1'b1;
        if (w_r_fire) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (w_rsp_fire) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command capture, write handshake tracking and response capture
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_fire) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_fire) begin
        r_w_done <= 1'b1;
      end
      if (w_b_fire) begin
        r_rsp_resp  <= bresp;
        r_rsp_rdata <= '0;
      end
      if (w_r_fire) begin
        r_rsp_rdata <= rdata;
        r_rsp_resp  <= rlast ? rresp : RESP_PROTO_ERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_master.sv
// tb/tb_axi_master.sv - directed and randomized bench for axi_master against a memory-model slave
module tb_axi_master;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awid, awvalid, awready;
  logic [2:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        arid, arvalid, arready;
  logic [2:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_master dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // slave knobs: wait cycles before each ready/valid, response codes
  int         aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] b_resp_k;
  bit         rlast0_k;

  // slave state and its memory
  bit          aw_got, w_got, ar_got, b_fire, r_fire;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [2:0]  cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [31:0] slv_mem [8];
  bit          slv_wr  [8];

  // reference model of what the client should observe
  logic [31:0] ref_mem [8];
  bit          ref_wr  [8];

  // AXI slave: every decision is made at the falling edge, so a ready/valid
  // pair seen here is exactly what the DUT samples at the next rising edge.
  always @(negedge aclk) begin
    if (areset) begin
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rdata = 0; rresp = 0; rlast = 0;
    end else begin
      if (b_fire) begin
        bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (aw_got && w_got) begin
        if (!bvalid) begin
          if (b_cnt >= b_dly) begin bvalid = 1; bresp = b_resp_k; end
          else b_cnt++;
        end
        if (bvalid && bready) begin
          b_fire = 1;
          for (int i = 0; i < 4; i++)
            if (cap_wstrb[i]) slv_mem[cap_awaddr][i*8 +: 8] = cap_wdata[i*8 +: 8];
          slv_wr[cap_awaddr] = 1;
        end
      end
      awready = 0;
      if (awvalid && !aw_got) begin
        if (aw_cnt >= aw_dly) begin awready = 1; aw_got = 1; cap_awaddr = awaddr; end
        else aw_cnt++;
      end
      wready = 0;
      if (wvalid && !w_got) begin
        if (w_cnt >= w_dly) begin wready = 1; w_got = 1; cap_wdata = wdata; cap_wstrb = wstrb; end
        else w_cnt++;
      end
      if (r_fire) begin
        rvalid = 0; r_fire = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0; rlast = 0;
      end else if (ar_got) begin
        if (!rvalid) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1;
            rdata  = slv_wr[cap_araddr] ? slv_mem[cap_araddr] : 32'h0;
            rresp  = slv_wr[cap_araddr] ? 2'b00 : 2'b10;
            rlast  = !rlast0_k;
          end else r_cnt++;
        end
        if (rvalid && rready) r_fire = 1;
      end
      arready = 0;
      if (arvalid && !ar_got) begin
        if (ar_cnt >= ar_dly) begin arready = 1; ar_got = 1; cap_araddr = araddr; end
        else ar_cnt++;
      end
    end
  end

  // per-transaction observations, cycle 0 = command accept edge
  int          acc_wait, t_aw, t_w, n_aw, n_w, t_b, t_ar, t_r, t_rsp;
  bit          stable_ok, hold_ok;
  logic [31:0] got_rdata;
  logic [1:0]  got_resp;

  task automatic run_cmd(input bit wr, input logic [2:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold);
    int cyc;
    t_aw = -1; t_w = -1; t_b = -1; t_ar = -1; t_r = -1; n_aw = 0; n_w = 0;
    stable_ok = 1; hold_ok = 1; acc_wait = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && acc_wait < 200) begin @(negedge aclk); acc_wait++; end
    @(negedge aclk);
    cmd_valid = 0;
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      if (awvalid) begin
        n_aw++; if (t_aw < 0) t_aw = cyc;
        if (awaddr !== a || awid !== 0 || awlen !== 0) stable_ok = 0;
      end
      if (wvalid) begin
        n_w++; if (t_w < 0) t_w = cyc;
        if (wdata !== d || wstrb !== s || wlast !== 1) stable_ok = 0;
      end
      if (arvalid) begin
        if (t_ar < 0) t_ar = cyc;
        if (araddr !== a) stable_ok = 0;
      end
      if (bready && t_b < 0) t_b = cyc;
      if (rready && t_r < 0) t_r = cyc;
      @(negedge aclk);
      cyc++;
    end
    t_rsp = cyc;
    if (cyc >= 200) chk("rsp_timeout", 1, 0);
    got_rdata = rsp_rdata; got_resp = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      if (!rsp_valid || rsp_rdata !== got_rdata || rsp_resp !== got_resp || cmd_ready ||
          awvalid || wvalid || arvalid || bready || rready) hold_ok = 0;
      @(negedge aclk);
    end
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
  endtask

  task automatic ref_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
    ref_wr[a] = 1;
  endtask

  task automatic set_knobs(input int aw, input int w, input int b, input int ar, input int r,
                           input logic [1:0] br, input bit rl0);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; b_resp_k = br; rlast0_k = rl0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          hold, exp_lat, bigger;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rs;

    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 0; ref_wr[i] = 0; slv_mem[i] = 0; slv_wr[i] = 0;
    end
    set_knobs(0, 0, 0, 0, 0, 2'b00, 0);
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(negedge aclk);

    // reset values and fixed attributes
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_addrs", {awaddr, araddr}, 0);
    chk("rst_wpayload", {wdata, wstrb}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp}, 0);
    chk("aw_attr", {awid, awlen, awsize, awburst, wlast}, {1'b0, 8'd0, 3'b010, 2'b01, 1'b1});
    chk("ar_attr", {arid, arlen, arsize, arburst}, {1'b0, 8'd0, 3'b010, 2'b01});
    areset = 0;
    @(negedge aclk);

    // write DEADBEEF to 5 with an always-ready slave
    run_cmd(1, 3'd5, 32'hDEADBEEF, 4'hF, 0);
    ref_write(3'd5, 32'hDEADBEEF, 4'hF);
    chk("wr_t_aw", t_aw, 1);
    chk("wr_t_w", t_w, 1);
    chk("wr_t_b", t_b, 2);
    chk("wr_t_rsp", t_rsp, 3);
    chk("wr_payload", stable_ok, 1);
    chk("wr_rsp", {got_rdata, got_resp}, {32'h0, 2'b00});
    chk("wr_slave_cap", {cap_awaddr, cap_wdata, cap_wstrb}, {3'd5, 32'hDEADBEEF, 4'hF});

    // back-to-back read of 5
    run_cmd(0, 3'd5, 32'h0, 4'h0, 0);
    chk("b2b_accept", acc_wait, 0);
    chk("rd_t_ar", t_ar, 1);
    chk("rd_t_r", t_r, 2);
    chk("rd_t_rsp", t_rsp, 3);
    chk("rd_rsp", {got_rdata, got_resp}, {32'hDEADBEEF, 2'b00});

    // unwritten address
    run_cmd(0, 3'd2, 32'h0, 4'h0, 0);
    chk("rd_unwritten", {got_rdata, got_resp}, {32'h0, 2'b10});

    // wready three cycles behind awready
    set_knobs(0, 3, 0, 0, 0, 2'b00, 0);
    run_cmd(1, 3'd3, 32'h1234_5678, 4'hF, 0);
    ref_write(3'd3, 32'h1234_5678, 4'hF);
    chk("wdly_n_aw", n_aw, 1);
    chk("wdly_n_w", n_w, 4);
    chk("wdly_stable", stable_ok, 1);
    chk("wdly_t_b", t_b, 5);
    chk("wdly_t_rsp", t_rsp, 6);

    // client stalls the response for 5 cycles
    set_knobs(0, 0, 0, 0, 0, 2'b00, 0);
    run_cmd(0, 3'd3, 32'h0, 4'h0, 5);
    chk("stall_hold", hold_ok, 1);
    chk("stall_rsp", {got_rdata, got_resp}, {32'h1234_5678, 2'b00});

    // reset while AW is back-pressured
    set_knobs(1000, 0, 0, 0, 0, 2'b00, 0);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd6; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 0;
    repeat (2) @(negedge aclk);
    chk("bp_awvalid_held", {awvalid, awaddr}, {1'b1, 3'd6});
    areset = 1;
    @(negedge aclk);
    chk("mid_rst_valids", {awvalid, wvalid, rsp_valid}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    @(negedge aclk);
    areset = 0;
    set_knobs(0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge aclk);
    run_cmd(0, 3'd6, 32'h0, 4'h0, 0);
    chk("post_rst_lat", t_rsp, 3);
    chk("post_rst_rd", {got_rdata, got_resp}, {32'h0, 2'b10});

    // read beat without rlast
    set_knobs(0, 0, 0, 0, 0, 2'b00, 1);
    run_cmd(0, 3'd5, 32'h0, 4'h0, 0);
    chk("no_rlast", {got_rdata, got_resp}, {32'hDEADBEEF, 2'b10});

    // randomized traffic against the reference model
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      set_knobs($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0));
      run_cmd(wr, a, d, s, hold);
      if (wr) begin
        bigger  = (aw_dly > w_dly) ? aw_dly : w_dly;
        exp_lat = bigger + b_dly + 3;
        exp_rd  = 0;
        exp_rs  = b_resp_k;
        chk("rnd_wr_cap", {cap_awaddr, cap_wdata, cap_wstrb}, {a, d, s});
        ref_write(a, d, s);
      end else begin
        exp_lat = ar_dly + r_dly + 3;
        exp_rd  = ref_wr[a] ? ref_mem[a] : 32'h0;
        exp_rs  = (ref_wr[a] && !rlast0_k) ? 2'b00 : 2'b10;
        chk("rnd_rd_cap", cap_araddr, a);
      end
      chk("rnd_lat", t_rsp, exp_lat);
      chk("rnd_rsp", {got_rdata, got_resp}, {exp_rd, exp_rs});
      chk("rnd_stable_hold", {stable_ok, hold_ok}, 2'b11);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
